// File: rtl/mult_shift_add_seq_pkg.sv
// mult_shift_add_seq_pkg: shared widths and state encoding for the shift-add multiplier.
package mult_shift_add_seq_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/mult_shift_add_seq_cla.sv
// adder_32bit_cla: 32-bit adder built from 4-bit full-lookahead groups.
module adder_32bit_cla
    import mult_shift_add_seq_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o
);
    logic [WIDTH-1:0] gen, prp;
    logic [WIDTH:0]   c;
    assign gen  = a_i & b_i;
    assign prp  = a_i ^ b_i;
    assign c[0] = cin_i;
    for (genvar i = 0; i < WIDTH / 4; i++) begin : grp
        localparam int base = 4 * i;
        assign c[base+1] = gen[base] | (prp[base] & c[base]);
        assign c[base+2] = gen[base+1] | (prp[base+1] & gen[base])
                         | (prp[base+1] & prp[base] & c[base]);
        assign c[base+3] = gen[base+2] | (prp[base+2] & gen[base+1])
                         | (prp[base+2] & prp[base+1] & gen[base])
                         | (prp[base+2] & prp[base+1] & prp[base] & c[base]);
        assign c[base+4] = gen[base+3] | (prp[base+3] & gen[base+2])
                         | (prp[base+3] & prp[base+2] & gen[base+1])
                         | (prp[base+3] & prp[base+2] & prp[base+1] & gen[base])
                         | ((&prp[base+3:base]) & c[base]);
    end
    assign s_o = prp ^ c[WIDTH-1:0];
    assign c_o = c[WIDTH];
endmodule

// File: rtl/mult_shift_add_seq.sv
// mult_shift_add_seq: unsigned 32x32->64 multiplier, one shift-add step per clock through a shared CLA.
module mult_shift_add_seq
    import mult_shift_add_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 flush_i,
    input  logic [WIDTH-1:0]     op_a_i,
    input  logic [WIDTH-1:0]     op_b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);
    state_e               state_q;
    logic [CNT_W-1:0]     count_q;
    logic [WIDTH-1:0]     m_q, sum;
    logic [2*WIDTH-1:0]   p_q, p_d, product_q;
    logic                 carry, busy_q, done_q;

    adder_32bit_cla u_add (
        .a_i  (p_q[2*WIDTH-1:WIDTH]),
        .b_i  (p_q[0] ? m_q : '0),
        .cin_i(1'b0),
        .s_o  (sum),
        .c_o  (carry)
    );

    // Carry lands in the top bit, so the 64-bit product never overflows.
    assign p_d = {carry, sum, p_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            m_q       <= '0;
            p_q       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    p_q     <= p_d;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= p_d;
                    end
                end
                default: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        m_q     <= op_a_i;
                        p_q     <= {{WIDTH{1'b0}}, op_b_i};
                        count_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;
endmodule

// File: tb/tb_mult_shift_add_seq.sv
// tb_mult_shift_add_seq: randomized scoreboard bench; expected products and done cycles are queued at issue.
module tb_mult_shift_add_seq;
    logic        clk = 0, rst = 0, start_i = 0, flush_i = 0;
    logic [31:0] op_a_i = 0, op_b_i = 0;
    logic        busy_o, done_o;
    logic [63:0] product_o;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0, errors = 0, cyc = 0, bcnt = 0;
    logic        prev_done = 0;
    logic [63:0] last_prod = 0;

    mult_shift_add_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .product_o(product_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: product %h at cycle %0d", product_o, cyc);
                end else begin
                    e = q.pop_front();
                    chk("product", product_o, e.prod);
                    chk("done_latency", 64'(cyc), 64'(e.cyc));
                    last_prod = e.prod;
                end
                chk("busy_run_len", 64'(bcnt), 64'd32);
                chk("busy_in_done", 64'(busy_o), 64'd0);
                chk("done_single_pulse", 64'(prev_done), 64'd0);
                bcnt = 0;
            end else if (busy_o) begin
                bcnt++;
            end else begin
                bcnt = 0;
            end
            prev_done = done_o;
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
        q.push_back('{prod: 64'(a) * 64'(b), cyc: cyc + 33});
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_i = 1; op_a_i = a; op_b_i = b;
        push_exp(a, b);
        @(negedge clk);
        start_i = 0; op_a_i = $urandom; op_b_i = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, b;
        int n;
        #1 rst = 1;
        #1;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_product", product_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 0;

        issue(32'd3, 32'd5);
        drain();
        chk("prod_3x5", product_o, 64'h0F);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue(32'd0, 32'h1234_5678);
        drain();
        issue(32'hFFFF_FFFF, 32'd1);
        drain();
        issue(32'h8000_0000, 32'h8000_0000);
        drain();

        // A second start while iterating must be ignored.
        issue(32'd7, 32'd9);
        repeat (10) @(negedge clk);
        start_i = 1; op_a_i = 32'hDEAD_BEEF; op_b_i = 32'h0BAD_F00D;
        @(negedge clk);
        start_i = 0;
        drain();

        // Start held through DONE launches the next op on the same edge that leaves DONE.
        a = $urandom; b = $urandom;
        @(negedge clk);
        start_i = 1; op_a_i = a; op_b_i = b;
        push_exp(a, b);
        @(negedge clk);
        op_a_i = $urandom; op_b_i = $urandom;
        n = 0;
        while (!done_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("held_start_first_done_seen", 64'(done_o), 64'd1);
        a = $urandom; b = $urandom;
        op_a_i = a; op_b_i = b;
        push_exp(a, b);
        @(negedge clk);
        start_i = 0;
        drain();

        // Flush at iteration 10: no done, product unchanged.
        issue($urandom, $urandom);
        repeat (9) @(negedge clk);
        flush_i = 1;
        @(negedge clk);
        flush_i = 0;
        void'(q.pop_back());
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_done", 64'(done_o), 64'd0);
        chk("flush_product", product_o, last_prod);
        repeat (40) @(negedge clk);
        chk("flush_product_held", product_o, last_prod);
        start_i = 1; flush_i = 1;
        @(negedge clk);
        start_i = 0; flush_i = 0;
        chk("flush_beats_start", 64'(busy_o), 64'd0);

        for (int i = 0; i < 12; i++) begin
            issue($urandom, $urandom);
            drain();
        end

        // Reset mid-run returns every output to zero at once.
        issue($urandom, $urandom);
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1;
        q.delete();
        chk("rst_run_busy", 64'(busy_o), 64'd0);
        chk("rst_run_done", 64'(done_o), 64'd0);
        chk("rst_run_product", product_o, 64'd0);
        @(negedge clk);
        rst = 0;
        issue(32'd6, 32'd7);
        drain();
        chk("after_rst_product", product_o, 64'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
